// File: rtl/eq_band_channel_pkg.sv
// Shared widths, sample/accumulator types and the signed saturation helper
// used by every equalizer band.
package eq_pkg;

  localparam int FILTER_IN_BITS  = 16;
  localparam int FILTER_OUT_BITS = 16;
  localparam int NUMBER_OF_TAPS  = 64;
  localparam int COEFF_BITS      = 16;
  localparam int COEFF_FRAC_BITS = 16;
  localparam int GAIN_BITS       = 2;
  localparam int GAIN_FRAC_BITS  = 0;

  localparam int TAP_IDX_BITS = $clog2(NUMBER_OF_TAPS);
  localparam int PROD_BITS    = FILTER_IN_BITS + COEFF_BITS;
  localparam int ACC_BITS     = FILTER_IN_BITS + COEFF_BITS + TAP_IDX_BITS;

  typedef logic signed [FILTER_IN_BITS-1:0]  sample_t;
  typedef logic signed [FILTER_OUT_BITS-1:0] out_t;
  typedef logic signed [COEFF_BITS-1:0]      coeff_t;
  typedef logic signed [ACC_BITS-1:0]        acc_t;

  // Clamp a wide signed value into the signed FILTER_OUT_BITS range.
  function automatic out_t sat_out(input acc_t x);
    acc_t max_v;
    acc_t min_v;
    max_v = acc_t'(2 ** (FILTER_OUT_BITS - 1) - 1);
    min_v = acc_t'(-(2 ** (FILTER_OUT_BITS - 1)));
    if (x > max_v) begin
      return out_t'(max_v);
    end else if (x < min_v) begin
      return out_t'(min_v);
    end
    return out_t'(x);
  endfunction

endpackage

// File: rtl/eq_band_channel_if.sv
// Sample, coefficient and status bundle of one equalizer band; the band itself
// is the slave, the driving controller (or bench) is the master.
interface eq_band_channel_if;
  import eq_pkg::*;

  logic                                 clk_enable;
  logic                                 amplifier_enable;
  logic [GAIN_BITS-1:0]                 gain;
  sample_t                              filter_in;
  logic [COEFF_BITS*NUMBER_OF_TAPS-1:0] coeffs_feed;
  logic [TAP_IDX_BITS-1:0]              current_count;
  logic                                 phase_min;
  out_t                                 filtered_out;

  modport master (
    output clk_enable, amplifier_enable, gain, filter_in, coeffs_feed,
    input  current_count, phase_min, filtered_out
  );

  modport slave (
    input  clk_enable, amplifier_enable, gain, filter_in, coeffs_feed,
    output current_count, phase_min, filtered_out
  );

endinterface

// File: rtl/eq_band_channel_tap_counter.sv
// Free-running tap-phase counter: 0 .. NUMBER_OF_TAPS-1, wrapping, one step per
// enabled cycle. phase_min marks the frame-boundary (count 0) cycle.
module tap_counter
  import eq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  output logic [TAP_IDX_BITS-1:0] count_o,
  output logic                    phase_min_o
);

  logic [TAP_IDX_BITS-1:0] count_q;
  logic [TAP_IDX_BITS-1:0] count_d;

  // Tap count is a power of two, so the natural binary overflow is the wrap.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = count_q + TAP_IDX_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign phase_min_o = (count_q == '0);

endmodule

// File: rtl/eq_band_channel.sv
// One equalizer band: optional gain stage, 64-tap serial-MAC FIR, saturated output.
// Define EQ_GAIN_EN to build the amplifier stage; otherwise samples pass unscaled.
module eq_band_channel
  import eq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  eq_band_channel_if.slave band_if
);

  logic [TAP_IDX_BITS-1:0] count;
  logic                    phase_min;

  tap_counter u_tap_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (band_if.clk_enable),
    .count_o     (count),
    .phase_min_o (phase_min)
  );

  assign band_if.current_count = count;
  assign band_if.phase_min     = phase_min;

  sample_t amp_out;

`ifdef EQ_GAIN_EN
  logic signed [FILTER_IN_BITS+GAIN_BITS:0] amp_prod;

  assign amp_prod = band_if.filter_in * $signed({1'b0, band_if.gain});
  assign amp_out  = band_if.amplifier_enable
                  ? sat_out(acc_t'(amp_prod >>> GAIN_FRAC_BITS))
                  : band_if.filter_in;
`else
  logic gain_unused;

  assign gain_unused = ^{band_if.amplifier_enable, band_if.gain};
  assign amp_out     = band_if.filter_in;
`endif

  sample_t                 delay_q [NUMBER_OF_TAPS];
  acc_t                    acc_q;
  acc_t                    acc_d;
  out_t                    out_q;
  out_t                    out_d;
  logic [TAP_IDX_BITS-1:0] tap_idx;
  sample_t                 tap_sample;
  coeff_t                  tap_coeff;
  logic signed [PROD_BITS-1:0] tap_prod;
  acc_t                    acc_sum;

  // Count 0 wraps to tap N-1, so the closing MAC reads the pre-shift oldest sample.
  assign tap_idx    = count - TAP_IDX_BITS'(1);
  assign tap_sample = delay_q[tap_idx];
  assign tap_coeff  = band_if.coeffs_feed[tap_idx*COEFF_BITS +: COEFF_BITS];
  assign tap_prod   = tap_sample * tap_coeff;
  assign acc_sum    = acc_q + acc_t'(tap_prod);

  always_comb begin
    acc_d = acc_sum;
    out_d = out_q;
    if (phase_min) begin
      acc_d = '0;
      out_d = sat_out(acc_sum >>> COEFF_FRAC_BITS);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      out_q <= '0;
      for (int k = 0; k < NUMBER_OF_TAPS; k++) begin
        delay_q[k] <= '0;
      end
    end else if (band_if.clk_enable) begin
      acc_q <= acc_d;
      out_q <= out_d;
      if (phase_min) begin
        delay_q[0] <= amp_out;
        for (int k = 1; k < NUMBER_OF_TAPS; k++) begin
          delay_q[k] <= delay_q[k-1];
        end
      end
    end
  end

  assign band_if.filtered_out = out_q;

endmodule

// File: tb/tb_eq_band_channel.sv
// Frame-level bench for eq_band_channel: each frame's output is predicted as a
// saturated, floor-scaled dot product of the sample history with the coefficients.
module tb_eq_band_channel;
  import eq_pkg::*;

  localparam int N = NUMBER_OF_TAPS;

  logic clk;
  logic rst_n;

  eq_band_channel_if band_if ();

  eq_band_channel dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .band_if (band_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     vectors     = 0;
  int     miscompares = 0;
  int     hist [N];
  int     coef [N];
  int     nextCoef [N];
  longint expOut;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    vectors++;
    if (observed != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint ampModel(input int x, input bit ampEn, input int g);
`ifdef EQ_GAIN_EN
    if (ampEn) return clamp16(longint'(x) * longint'(g));
`endif
    return longint'(x);
  endfunction

  function automatic longint frameResult();
    longint s;
    s = 0;
    for (int k = 0; k < N; k++) s += longint'(hist[k]) * longint'(coef[k]);
    return clamp16(s >>> 16);
  endfunction

  function automatic int rand16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  // mode: 0 plain, 1 enable freeze mid-frame, 2 reset mid-frame, 3 scramble inputs after capture
  task automatic applyStimulus(input int x, input bit ampEn, input int g, input int mode);
    band_if.filter_in        = 16'(x);
    band_if.amplifier_enable = ampEn;
    band_if.gain             = 2'(g);
    checkOutput("phase_min_at_boundary", longint'(band_if.phase_min), 1);
    @(posedge clk); #1;
    checkOutput("out_at_capture", longint'(band_if.filtered_out), expOut);
    for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'(ampModel(x, ampEn, g));
    coef = nextCoef;
    for (int k = 0; k < N; k++) band_if.coeffs_feed[k*COEFF_BITS +: COEFF_BITS] = COEFF_BITS'(nextCoef[k]);
    if (mode == 3) begin
      band_if.filter_in        = 16'($urandom);
      band_if.gain             = 2'($urandom);
      band_if.amplifier_enable = 1'($urandom);
    end
    for (int i = 1; i < N; i++) begin
      if (i == 20 && mode == 1) begin
        band_if.clk_enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("count_frozen", longint'(band_if.current_count), 20);
        checkOutput("out_frozen", longint'(band_if.filtered_out), expOut);
        band_if.clk_enable = 1'b1;
      end
      if (i == 20 && mode == 2) begin
        #3 rst_n = 1'b0;
        #1;
        checkOutput("count_after_reset", longint'(band_if.current_count), 0);
        checkOutput("phase_min_after_reset", longint'(band_if.phase_min), 1);
        checkOutput("out_after_reset", longint'(band_if.filtered_out), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < N; k++) hist[k] = 0;
        expOut = 0;
        return;
      end
      if (i == 32) begin
        checkOutput("count_mid_frame", longint'(band_if.current_count), 32);
        checkOutput("out_stable_mid_frame", longint'(band_if.filtered_out), expOut);
      end
      @(posedge clk); #1;
    end
    checkOutput("count_wrapped", longint'(band_if.current_count), 0);
    expOut = frameResult();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n                    = 1'b0;
    band_if.clk_enable       = 1'b1;
    band_if.amplifier_enable = 1'b0;
    band_if.gain             = '0;
    band_if.filter_in        = '0;
    band_if.coeffs_feed      = '0;
    for (int k = 0; k < N; k++) begin
      hist[k] = 0; coef[k] = 0; nextCoef[k] = 0;
    end
    expOut = 0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_count", longint'(band_if.current_count), 0);
    checkOutput("reset_phase_min", longint'(band_if.phase_min), 1);
    checkOutput("reset_out", longint'(band_if.filtered_out), 0);
    #2 rst_n = 1'b1;

    $display("[TB] pass-through tap, gain and gain saturation");
    nextCoef[0] = 16384;
    repeat (3) applyStimulus(4000, 1'b0, 0, 0);
    repeat (2) applyStimulus(4000, 1'b1, 2, 0);
    repeat (2) applyStimulus(4000, 1'b1, 0, 0);
    repeat (2) applyStimulus(30000, 1'b1, 3, 0);

    $display("[TB] delay alignment on tap 3");
    nextCoef[0] = 0;
    nextCoef[3] = 16384;
    repeat (4) applyStimulus(0, 1'b0, 0, 0);
    applyStimulus(4000, 1'b0, 0, 0);
    repeat (6) applyStimulus(0, 1'b0, 0, 0);

    $display("[TB] full-scale saturation");
    for (int k = 0; k < N; k++) nextCoef[k] = 32767;
    repeat (N) applyStimulus(32767, 1'b0, 0, 0);
    repeat (N) applyStimulus(-32768, 1'b0, 0, 0);

    $display("[TB] enable freeze and mid-frame reset");
    for (int k = 0; k < N; k++) nextCoef[k] = int'($urandom_range(1023)) - 512;
    applyStimulus(1234, 1'b0, 0, 1);
    applyStimulus(-777, 1'b0, 0, 0);
    applyStimulus(5000, 1'b0, 0, 2);
    applyStimulus(3000, 1'b0, 0, 0);
    applyStimulus(-2500, 1'b0, 0, 0);

    $display("[TB] randomized frames");
    repeat (40) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(3) == 0) nextCoef[k] = rand16();
        else nextCoef[k] = int'($urandom_range(1023)) - 512;
      end
      applyStimulus(rand16(), 1'($urandom), int'($urandom_range(3)), 3);
    end
    applyStimulus(0, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
